fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Program-counter and IF/ID pipeline-register stage sitting directly upstream of the instruction memory. It drives the fetch address, captures the returned instruction word into the IF/ID register, and applies the next-PC selection: sequential, branch, jump or stall. It also detects the halt opcode (6'b111111) and drains the pipeline into a terminal HALTED state.

Parameters:
DRAIN_CYCLES, 3, bubble cycles issued after a halt fetch before asserting o_Halted (covers ID/EX/MEM); legal range 1..15
COUNT_W, 16, width of the retired-fetch counter

Ports:
i_Clk  in  1  clock; all state updates on the rising edge
i_Rst  in  1  reset; asynchronous, active-high
i_Stall  in  1  hazard-unit stall; holds the PC and IF/ID register
i_Branch_Taken  in  1  branch resolved taken (from EX)
i_Branch_Target  in  32  branch target byte address
i_Jump  in  1  jump decoded (from ID)
i_Jump_Target  in  32  jump target byte address
i_Instruction  in  32  word returned by the instruction memory for o_Addr (combinational, same cycle)
o_Addr  out  32  fetch address (the current PC) to the instruction memory
o_IFID_Instruction  out  32  latched instruction
o_IFID_PC_Plus4  out  32  PC+4 of the latched instruction
o_IFID_Valid  out  1  IF/ID holds a real instruction
o_Halted  out  1  halt reached and drained
o_Fetch_Count  out  COUNT_W  number of valid instructions latched into IF/ID

Behaviour:
- States: START, RUN, DRAIN, HALTED. The PC register drives o_Addr directly.
- Reset (asynchronous, any state):
  - PC = 32'hFFFF_FFFC (-4), so the instruction memory returns its halt word.
  - State = START. o_IFID_Instruction = 0, o_IFID_PC_Plus4 = 0, o_IFID_Valid = 0, o_Halted = 0, o_Fetch_Count = 0.
- A bubble means: o_IFID_Instruction = 32'h0000_0000, o_IFID_Valid = 0, o_IFID_PC_Plus4 = 0.
- START:
  - The first edge after reset release sets PC = 0, loads a bubble into IF/ID, and moves to RUN.
  - The word fetched at -4 is always ignored.
  - i_Stall, i_Branch_Taken and i_Jump are ignored in START.
- Redirect priority: i_Branch_Taken > i_Jump > i_Stall > sequential. A redirect overrides a simultaneous stall because it comes from an older instruction.
- Targets: bits [1:0] of both targets are forced to 0 before loading the PC.
- RUN, each edge:
  - Branch taken: PC = branch target; IF/ID = bubble.
  - Else jump: PC = jump target; IF/ID = bubble.
  - Else stall: PC, IF/ID and counter all hold.
  - Else if i_Instruction[31:26] == 6'b111111: PC holds; IF/ID = bubble; drain counter = DRAIN_CYCLES-1; go to DRAIN. The halt word is never marked valid.
  - Else: IF/ID = {i_Instruction, PC+4, valid=1}; PC = PC+4; o_Fetch_Count increments.
- PC arithmetic: PC+4 wraps modulo 2^32.
- o_Fetch_Count saturates at all-ones.
- DRAIN, each edge:
  - Branch taken or jump: PC = target (same priority rules); IF/ID = bubble; go to RUN. This cancels a speculative halt.
  - Else stall: drain counter holds.
  - Else if drain counter == 0: go to HALTED.
  - Else: drain counter decrements.
  - IF/ID stays bubble and PC holds the halt address throughout.
- HALTED:
  - o_Halted = 1 (registered, asserted from the edge that enters HALTED).
  - All inputs are ignored; PC holds the halt address; IF/ID stays bubble.
  - Only i_Rst leaves this state.
- The IF/ID outputs and o_Halted are registered; o_Addr equals the PC register.
- Fetch latency: an instruction at address A appears on the IF/ID outputs one edge after PC == A.

Test Plan:
- Reset/start: assert i_Rst -> o_Addr = FFFFFFFC, o_IFID_Valid = 0, o_Halted = 0. Release -> edge 1: o_Addr = 0, IF/ID bubble. Edge 2: IF/ID = mem[0], PC_Plus4 = 4, Valid = 1, o_Addr = 4, o_Fetch_Count = 1.
- Stall: i_Stall = 1 for 2 cycles with PC = 8 -> o_Addr stays 8, IF/ID and counter unchanged. Release -> the next edge latches mem[2] and o_Addr = C.
- Priority: i_Branch_Taken = 1 (target 0x43), i_Jump = 1 (target 0x80) and i_Stall = 1 on the same edge -> o_Addr = 0x40, IF/ID bubble, counter unchanged.
- Halt: halt word 32'hFC00_0000 at 0x10, DRAIN_CYCLES = 3, no stalls -> o_Addr holds 0x10, Valid = 0 thereafter, and o_Halted rises exactly 4 edges after PC = 0x10 is presented (1 edge into DRAIN, 3 drain edges). Further branch/jump pulses have no effect.
- Cancelled halt: a branch to 0x20 on the second DRAIN edge -> RUN, o_Addr = 0x20, o_Halted stays 0, and the next edge latches mem[8].
- Async reset in HALTED: pulse i_Rst between clock edges -> o_Addr = FFFFFFFC, o_Halted = 0 and o_Fetch_Count = 0 immediately (before the next edge); then the start sequence repeats.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and IF/ID pipeline register. Selects the next PC (branch, jump, stall
// or sequential), latches fetched words, and drains the pipeline to HALTED on the halt opcode.
module fetch_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int COUNT_W      = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Stall,
    input  logic               i_Branch_Taken,
    input  logic [31:0]        i_Branch_Target,
    input  logic               i_Jump,
    input  logic [31:0]        i_Jump_Target,
    input  logic [31:0]        i_Instruction,
    output logic [31:0]        o_Addr,
    output logic [31:0]        o_IFID_Instruction,
    output logic [31:0]        o_IFID_PC_Plus4,
    output logic               o_IFID_Valid,
    output logic               o_Halted,
    output logic [COUNT_W-1:0] o_Fetch_Count
);

    localparam logic [31:0] RESET_PC   = 32'hFFFF_FFFC;
    localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [5:0]  HALT_OP    = 6'b111111;

    typedef enum logic [1:0] {
        START,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        pc, pc_nxt;
    logic [31:0]        ifid_instr, ifid_instr_nxt;
    logic [31:0]        ifid_pc4, ifid_pc4_nxt;
    logic               ifid_valid, ifid_valid_nxt;
    logic               halted_nxt;
    logic [COUNT_W-1:0] fetch_count, fetch_count_nxt;
    logic [3:0]         drain_cnt, drain_cnt_nxt;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        pc_plus4;

    // Branch outranks jump: it resolves in EX, an older instruction than the jump in ID.
    assign redirect    = i_Branch_Taken | i_Jump;
    assign redirect_pc = i_Branch_Taken ? (i_Branch_Target & ~32'd3)
                                        : (i_Jump_Target   & ~32'd3);
    assign pc_plus4    = pc + 32'd4;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path through the case leaves a latch.
        state_nxt       = state;
        pc_nxt          = pc;
        ifid_instr_nxt  = 32'h0;
        ifid_pc4_nxt    = 32'h0;
        ifid_valid_nxt  = 1'b0;
        fetch_count_nxt = fetch_count;
        drain_cnt_nxt   = drain_cnt;

        unique case (state)
            START: begin
                pc_nxt    = 32'h0;
                state_nxt = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end else if (i_Stall) begin
                    ifid_instr_nxt = ifid_instr;
                    ifid_pc4_nxt   = ifid_pc4;
                    ifid_valid_nxt = ifid_valid;
                end else if (i_Instruction[31:26] == HALT_OP) begin
                    drain_cnt_nxt = DRAIN_INIT;
                    state_nxt     = DRAIN;
                end else begin
                    ifid_instr_nxt = i_Instruction;
                    ifid_pc4_nxt   = pc_plus4;
                    ifid_valid_nxt = 1'b1;
                    pc_nxt         = pc_plus4;
                    if (fetch_count != '1)
                        fetch_count_nxt = fetch_count + COUNT_W'(1);
                end
            end
            DRAIN: begin
                // A redirect here means the halt was fetched down a mispredicted path.
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = RUN;
                end else if (!i_Stall) begin
                    if (drain_cnt == 4'd0)
                        state_nxt = HALTED;
                    else
                        drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: state_nxt = START;
        endcase

        halted_nxt = (state_nxt == HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= START;
            pc          <= RESET_PC;
            ifid_instr  <= 32'h0;
            ifid_pc4    <= 32'h0;
            ifid_valid  <= 1'b0;
            o_Halted    <= 1'b0;
            fetch_count <= '0;
            drain_cnt   <= 4'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ifid_instr  <= ifid_instr_nxt;
            ifid_pc4    <= ifid_pc4_nxt;
            ifid_valid  <= ifid_valid_nxt;
            o_Halted    <= halted_nxt;
            fetch_count <= fetch_count_nxt;
            drain_cnt   <= drain_cnt_nxt;
        end
    end

    assign o_Addr             = pc;
    assign o_IFID_Instruction = ifid_instr;
    assign o_IFID_PC_Plus4    = ifid_pc4;
    assign o_IFID_Valid       = ifid_valid;
    assign o_Fetch_Count      = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a behavioural instruction memory plus a reference
// model of the fetch rules, compared after every clock edge and on asynchronous reset.
module tb_fetch_unit;

    localparam int DRAIN = 3;
    localparam int CW    = 5;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, br_taken, jump;
    logic [31:0]   br_target, jump_target, instr;
    logic [31:0]   addr, ifid_instr, ifid_pc4;
    logic          ifid_valid, halted;
    logic [CW-1:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(.DRAIN_CYCLES(DRAIN), .COUNT_W(CW)) dut (
        .i_Clk              (clk),
        .i_Rst              (rst),
        .i_Stall            (stall),
        .i_Branch_Taken     (br_taken),
        .i_Branch_Target    (br_target),
        .i_Jump             (jump),
        .i_Jump_Target      (jump_target),
        .i_Instruction      (instr),
        .o_Addr             (addr),
        .o_IFID_Instruction (ifid_instr),
        .o_IFID_PC_Plus4    (ifid_pc4),
        .o_IFID_Valid       (ifid_valid),
        .o_Halted           (halted),
        .o_Fetch_Count      (fetch_count)
    );

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_cnt;
    bit          m_started, m_draining, m_halted;
    int          m_drain_edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return {6'h01, a[25:0]};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 32'hFFFF_FFFC;
        m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        m_started = 0; m_draining = 0; m_halted = 0; m_drain_edges = 0;
    endtask

    task automatic bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endtask

    task automatic model_edge(input bit st, input bit bt, input logic [31:0] btgt,
                              input bit jp, input logic [31:0] jtgt, input logic [31:0] w);
        if (m_halted) begin
        end else if (!m_started) begin
            m_started = 1; m_pc = 0; bubble();
        end else if (bt || jp) begin
            m_pc = (bt ? btgt : jtgt) & ~32'd3;
            m_draining = 0;
            bubble();
        end else if (st) begin
        end else if (m_draining) begin
            m_drain_edges--;
            if (m_drain_edges == 0) begin
                m_halted = 1; m_draining = 0;
            end
        end else if (w[31:26] == 6'h3F) begin
            bubble();
            m_draining = 1;
            m_drain_edges = DRAIN;
        end else begin
            m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1;
            m_pc = m_pc + 32'd4;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_addr"},  addr, m_pc);
        check({tag, "_instr"}, ifid_instr, m_instr);
        check({tag, "_pc4"},   ifid_pc4, m_pc4);
        check({tag, "_valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        check({tag, "_halt"},  {31'b0, halted}, {31'b0, m_halted});
        check({tag, "_count"}, {{(32-CW){1'b0}}, fetch_count}, m_cnt);
    endtask

    // Called just after an active edge; drives inputs, clocks once, then compares.
    task automatic cycle(input bit st, input bit bt, input logic [31:0] btgt,
                         input bit jp, input logic [31:0] jtgt, input string tag);
        logic [31:0] w;
        stall = st; br_taken = bt; br_target = btgt; jump = jp; jump_target = jtgt;
        instr = fetch_word(addr);
        w = fetch_word(m_pc);
        @(posedge clk);
        #1;
        model_edge(st, bt, btgt, jp, jtgt, w);
        check_all(tag);
    endtask

    task automatic seq(input string tag);
        cycle(0, 0, 0, 0, 0, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    task automatic rand_cycle(input string tag);
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom & 32'hFF,
              $urandom_range(0, 7) == 0, $urandom & 32'hFF, tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = rand_word();
        rst = 1'b1;
        stall = 0; br_taken = 0; jump = 0; br_target = 0; jump_target = 0; instr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst = 1'b0;

        seq("start");
        seq("seq0");
        check("first_pc4", ifid_pc4, 32'h4);
        seq("seq1");
        cycle(1, 0, 0, 0, 0, "stall_a");
        cycle(1, 0, 0, 0, 0, "stall_b");
        check("stall_hold", addr, 32'h8);
        seq("unstall");
        check("unstall_instr", ifid_instr, mem[2]);
        check("unstall_addr", addr, 32'hC);

        cycle(1, 1, 32'h43, 1, 32'h80, "prio");
        check("prio_addr", addr, 32'h40);

        cycle(0, 1, 32'hFFFF_FFF8, 0, 0, "wrap_br");
        seq("wrap_a");
        seq("wrap_b");
        check("wrap_pc4", ifid_pc4, 32'h0);

        for (int i = 0; i < 200; i++) rand_cycle("rand1");
        check("count_sat", {{(32-CW){1'b0}}, fetch_count}, 32'd31);

        mem[4] = HALT_WORD;
        cycle(0, 0, 0, 1, 32'h10, "halt_jmp");
        seq("halt_e1");
        seq("halt_e2");
        seq("halt_e3");
        check("halt_early", {31'b0, halted}, 32'd0);
        seq("halt_e4");
        check("halt_rise", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 4; i++)
            cycle($urandom_range(0, 1), 1, 32'h40, 1, 32'h80, "halted_ign");
        check("halted_addr", addr, 32'h10);

        async_reset("rst_halted");
        seq("restart");
        check("restart_addr", addr, 32'h0);

        cycle(0, 0, 0, 1, 32'h10, "cancel_jmp");
        seq("cancel_d0");
        seq("cancel_d1");
        cycle(0, 1, 32'h20, 0, 0, "cancel_br");
        check("cancel_addr", addr, 32'h20);
        seq("cancel_next");
        check("cancel_instr", ifid_instr, mem[8]);

        mem[12] = HALT_WORD;
        mem[30] = 32'hFFFF_FFFF;
        for (int i = 0; i < 300; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) async_reset("rand_rst");
            rand_cycle("rand2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
